motor_cmd_scheduler: RTL and testbench
======================================

Name: motor_cmd_scheduler

Overview:
Arbitrates motor commands (direction + speed) from several requesters and sequences them into one shared UART JSON command sender through a valid/ready handshake. Also handles the emergency-stop override, periodic re-send (heartbeat) of the active command, and a watchdog that forces stop when requesters go silent. Sits between the direction/speed sources (keys, autonomous logic, safety) and the forward/backwards/stop sender datapath.

Parameters:
NUM_REQ, 3, number of requesters; index 0 = highest priority
REFRESH_CYCLES, 5_000_000, clk cycles between re-sends of the unchanged active command (100 ms at 50 MHz); must be >= 2
WATCHDOG_CYCLES, 50_000_000, clk cycles without any accepted request before a forced stop; 0 disables

Ports:
clk  in  1  system clock (50 MHz)
rst  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  single-cycle request strobe per requester
req_dir  in  2*NUM_REQ  direction per requester, packed, requester i at [2i+1:2i]; 00 fwd, 01 back, 1x stop
req_speed  in  3*NUM_REQ  speed per requester, packed, requester i at [3i+2:3i]
estop  in  1  level-sensitive emergency stop
cmd_valid  out  1  command offered to the UART sender
cmd_ready  in  1  sender accepts the command (transfer when cmd_valid && cmd_ready)
cmd_dir  out  2  offered/last-sent direction
cmd_speed  out  3  offered/last-sent speed
active_src  out  $clog2(NUM_REQ+1)  source of the last sent command; NUM_REQ = internal (reset/estop/watchdog)
estop_active  out  1  registered copy of estop

Behaviour:
- Reset values: cmd_valid 0, cmd_dir 2'b10, cmd_speed 0, active_src NUM_REQ, estop_active 0. Internal state: current = {10,0}, pending empty, refresh counter 0, watchdog counter 0, state STARTUP.
- Stop normalisation: any dir 1x is stored as 10 with speed 0 everywhere (pending, current, outputs).
- States: STARTUP -> ISSUE (stop, src NUM_REQ) on the first cycle after reset deasserts. IDLE, ISSUE, GAP.
- Arbitration: each cycle the lowest index i with req_valid[i]=1 wins. Other simultaneous strobes are dropped.
- The winner is written to pending if pending is empty or i <= pending source. Otherwise it is dropped. Every accepted request clears the watchdog counter.
- estop high: all req_valid ignored. On the cycle estop is first seen high, pending = stop with src NUM_REQ, which unconditionally overwrites any pending entry.
- IDLE: the refresh counter increments each cycle.
  - If pending is valid and differs from current -> ISSUE with pending; pending cleared.
  - If pending equals current -> pending cleared with no issue.
  - Else if the refresh counter == REFRESH_CYCLES-1 -> ISSUE re-sending current with the same src.
  - Pending beats refresh on the same cycle.
- ISSUE: cmd_valid=1; cmd_dir/cmd_speed are held stable until the handshake. New requests only update pending.
  - On cmd_valid && cmd_ready: current and active_src are updated, the refresh counter is cleared, next state GAP.
- GAP: cmd_valid=0 for exactly one cycle -> IDLE. The minimum spacing between transfers is therefore 2 cycles; pending is evaluated in IDLE.
- Latency: a request strobed in cycle t while IDLE with a free sender gives cmd_valid=1 at t+2 (t+1 pending registered, t+2 ISSUE).
- Watchdog: the counter increments every cycle and saturates. When it reaches WATCHDOG_CYCLES while current is not stop and pending is empty, it injects pending stop (src NUM_REQ) and clears.
- Reset mid-ISSUE: cmd_valid drops on that edge; the sequence restarts at STARTUP.

Test Plan:
- Reset release with cmd_ready=1 -> cmd_valid pulses with dir 10, speed 0, active_src 3; then no transfer for REFRESH_CYCLES (100 in the bench) until the refresh re-send.
- req_valid=3'b110 with req 1 = {00,5} and req 2 = {01,7} in the same cycle -> exactly one transfer {00,5}, active_src 1.
- cmd_ready held 0 for 20 cycles during ISSUE {00,3}; req 2 {01,4} arrives -> outputs stay {00,3} until ready; then GAP 1 cycle; then {01,4} issued.
- estop rises while running {00,6} -> next transfer {10,0}, active_src 3. req_valid asserted during estop -> no transfers except refreshes.
- No requests for WATCHDOG_CYCLES (1000) after {01,2} -> stop issued at count 1000; WATCHDOG_CYCLES=0 -> no stop.
- Repeat request identical to current {00,5} -> no extra transfer; the refresh period is unchanged.

Source files
------------

// File: rtl/motor_cmd_scheduler.sv
// motor_cmd_scheduler
//   Arbitrates direction/speed commands from NUM_REQ requesters (index 0 has
//   the highest priority) into a single UART JSON command sender over a
//   valid/ready handshake. Adds emergency-stop override, a periodic re-send
//   of the active command and a watchdog that forces stop when requesters
//   go quiet.
//
// Ports
//   clk, rst      50 MHz clock, synchronous active-high reset
//   req_valid     per-requester single-cycle strobe
//   req_dir       packed 2-bit direction per requester (00 fwd, 01 back, 1x stop)
//   req_speed     packed 3-bit speed per requester
//   estop         level-sensitive emergency stop
//   cmd_valid     command offered to the sender
//   cmd_ready     sender accepts (transfer on cmd_valid && cmd_ready)
//   cmd_dir       offered / last-sent direction
//   cmd_speed     offered / last-sent speed
//   active_src    source of the last sent command (NUM_REQ = internal)
//   estop_active  registered copy of estop
module motor_cmd_scheduler #(
  parameter int NUM_REQ         = 3,
  parameter int REFRESH_CYCLES  = 5_000_000,
  parameter int WATCHDOG_CYCLES = 50_000_000
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [2*NUM_REQ-1:0]               req_dir,
  input  logic [3*NUM_REQ-1:0]               req_speed,
  input  logic                               estop,
  output logic                               cmd_valid,
  input  logic                               cmd_ready,
  output logic [1:0]                         cmd_dir,
  output logic [2:0]                         cmd_speed,
  output logic [$clog2(NUM_REQ+1)-1:0]       active_src,
  output logic                               estop_active
);

  localparam int SRC_W = $clog2(NUM_REQ + 1);
  localparam int REF_W = $clog2(REFRESH_CYCLES + 1);
  localparam int WD_W  = (WATCHDOG_CYCLES > 0) ? $clog2(WATCHDOG_CYCLES + 1) : 1;

  localparam logic [SRC_W-1:0] SRC_INT  = SRC_W'(NUM_REQ);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(WATCHDOG_CYCLES);
  localparam logic [1:0]       DIR_STOP = 2'b10;

  typedef enum logic [1:0] {STARTUP, IDLE, ISSUE, GAP} state_t;

  // Any 1x direction collapses to a canonical stop so equality checks work.
  function automatic logic [1:0] norm_dir(input logic [1:0] d);
    return d[1] ? DIR_STOP : d;
  endfunction

  function automatic logic [2:0] norm_speed(input logic [1:0] d, input logic [2:0] s);
    return d[1] ? 3'd0 : s;
  endfunction

  function automatic logic [WD_W-1:0] sat_inc_wd(input logic [WD_W-1:0] v);
    return (v >= WD_LIMIT) ? WD_LIMIT : v + WD_W'(1);
  endfunction

  state_t             state, state_n;
  logic               pend_vld;
  logic [1:0]         pend_dir;
  logic [2:0]         pend_speed;
  logic [SRC_W-1:0]   pend_src;
  logic [1:0]         cur_dir;
  logic [2:0]         cur_speed;
  logic [SRC_W-1:0]   offer_src;
  logic [REF_W-1:0]   ref_cnt;
  logic [WD_W-1:0]    wd_cnt;

  logic               win_vld;
  logic [SRC_W-1:0]   win_src;
  logic [1:0]         win_dir;
  logic [2:0]         win_speed;
  logic               consume, estop_rise, req_acc, wd_fire, handshake;
  logic               load_offer;
  logic [1:0]         off_dir;
  logic [2:0]         off_speed;
  logic [SRC_W-1:0]   off_src;

  assign cmd_valid  = (state == ISSUE);
  assign handshake  = cmd_valid && cmd_ready;
  assign estop_rise = estop && !estop_active;
  // IDLE always retires a pending entry, so a same-cycle request sees a free slot.
  assign consume    = (state == IDLE) && pend_vld;
  assign req_acc    = !estop && win_vld && (!pend_vld || consume || (win_src <= pend_src));
  assign wd_fire    = (WATCHDOG_CYCLES != 0) && (wd_cnt == WD_LIMIT) && !cur_dir[1] && !pend_vld;

  // Fixed priority: scan high to low so the lowest set index wins.
  always_comb begin
    win_vld   = 1'b0;
    win_src   = '0;
    win_dir   = DIR_STOP;
    win_speed = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        win_vld   = 1'b1;
        win_src   = SRC_W'(i);
        win_dir   = norm_dir(req_dir[2*i +: 2]);
        win_speed = norm_speed(req_dir[2*i +: 2], req_speed[3*i +: 3]);
      end
    end
  end

  always_comb begin
    state_n    = state;
    load_offer = 1'b0;
    off_dir    = cur_dir;
    off_speed  = cur_speed;
    off_src    = active_src;
    case (state)
      STARTUP: begin
        state_n    = ISSUE;
        load_offer = 1'b1;
        off_dir    = DIR_STOP;
        off_speed  = 3'd0;
        off_src    = SRC_INT;
      end
      IDLE: begin
        // A pending entry equal to current is dropped silently; the refresh
        // schedule keeps running in that case.
        if (pend_vld && ((pend_dir != cur_dir) || (pend_speed != cur_speed))) begin
          state_n    = ISSUE;
          load_offer = 1'b1;
          off_dir    = pend_dir;
          off_speed  = pend_speed;
          off_src    = pend_src;
        end else if (ref_cnt == REF_LAST) begin
          state_n    = ISSUE;
          load_offer = 1'b1;
        end
      end
      ISSUE: begin
        if (cmd_ready) state_n = GAP;
      end
      GAP: state_n = IDLE;
      default: state_n = STARTUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= STARTUP;
      estop_active <= 1'b0;
      cmd_dir      <= DIR_STOP;
      cmd_speed    <= 3'd0;
      offer_src    <= SRC_INT;
      cur_dir      <= DIR_STOP;
      cur_speed    <= 3'd0;
      active_src   <= SRC_INT;
      ref_cnt      <= '0;
      wd_cnt       <= '0;
      pend_vld     <= 1'b0;
      pend_dir     <= DIR_STOP;
      pend_speed   <= 3'd0;
      pend_src     <= SRC_INT;
    end else begin
      state        <= state_n;
      estop_active <= estop;

      // cmd_dir/cmd_speed hold the offer until the handshake, then equal current.
      if (load_offer) begin
        cmd_dir   <= off_dir;
        cmd_speed <= off_speed;
        offer_src <= off_src;
      end

      if (handshake) begin
        cur_dir    <= cmd_dir;
        cur_speed  <= cmd_speed;
        active_src <= offer_src;
        ref_cnt    <= '0;
      end else if (state == IDLE) begin
        ref_cnt    <= ref_cnt + REF_W'(1);
      end

      // Pending writers in priority order: estop edge, request, watchdog.
      if (estop_rise) begin
        pend_vld   <= 1'b1;
        pend_dir   <= DIR_STOP;
        pend_speed <= 3'd0;
        pend_src   <= SRC_INT;
      end else if (req_acc) begin
        pend_vld   <= 1'b1;
        pend_dir   <= win_dir;
        pend_speed <= win_speed;
        pend_src   <= win_src;
      end else if (wd_fire) begin
        pend_vld   <= 1'b1;
        pend_dir   <= DIR_STOP;
        pend_speed <= 3'd0;
        pend_src   <= SRC_INT;
      end else if (consume) begin
        pend_vld   <= 1'b0;
      end

      if (req_acc || wd_fire) wd_cnt <= '0;
      else                    wd_cnt <= sat_inc_wd(wd_cnt);
    end
  end

endmodule

// File: tb/tb_motor_cmd_scheduler.sv
// Testbench for motor_cmd_scheduler: directed scenarios followed by random
// traffic, compared every cycle against a behavioural reference model.
module tb_motor_cmd_scheduler;

  localparam int N   = 3;
  localparam int REF = 100;
  localparam int WD  = 1000;
  localparam int M_START = 0, M_IDLE = 1, M_OFFER = 2, M_GAP = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] rv  = '0;
  logic [5:0] rd  = '0;
  logic [8:0] rs  = '0;
  logic       es  = 1'b0;
  logic       rdy = 1'b1;

  logic       cv, ea, cv2, ea2;
  logic [1:0] cd, cd2, asrc, asrc2;
  logic [2:0] cs, cs2;

  always #5 clk = ~clk;

  motor_cmd_scheduler #(.NUM_REQ(N), .REFRESH_CYCLES(REF), .WATCHDOG_CYCLES(WD)) dut (
    .clk(clk), .rst(rst), .req_valid(rv), .req_dir(rd), .req_speed(rs), .estop(es),
    .cmd_valid(cv), .cmd_ready(rdy), .cmd_dir(cd), .cmd_speed(cs),
    .active_src(asrc), .estop_active(ea));

  motor_cmd_scheduler #(.NUM_REQ(N), .REFRESH_CYCLES(REF), .WATCHDOG_CYCLES(0)) dut_nowd (
    .clk(clk), .rst(rst), .req_valid(rv), .req_dir(rd), .req_speed(rs), .estop(es),
    .cmd_valid(cv2), .cmd_ready(rdy), .cmd_dir(cd2), .cmd_speed(cs2),
    .active_src(asrc2), .estop_active(ea2));

  int checks = 0, errors = 0;
  int dut_xfers = 0, x0 = 0;
  bit got;

  // Reference model state
  int m_ph, m_cur_dir, m_cur_spd, m_src, m_off_dir, m_off_spd, m_off_src;
  int m_pv, m_pd, m_psp, m_ps, m_ref, m_wd, m_es;

  task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got_v, exp_v, $time);
    end
  endtask

  task automatic model_step();
    int  w;
    bit  consume, erise, acc, wd_hit;
    if (rst) begin
      m_ph = M_START; m_cur_dir = 2; m_cur_spd = 0; m_src = N;
      m_off_dir = 2; m_off_spd = 0; m_off_src = N;
      m_pv = 0; m_pd = 2; m_psp = 0; m_ps = N; m_ref = 0; m_wd = 0; m_es = 0;
      return;
    end
    w = -1;
    for (int i = 0; i < N; i++) if (rv[i] && w < 0) w = i;
    consume = (m_ph == M_IDLE) && (m_pv != 0);
    erise   = es && (m_es == 0);
    acc     = !es && (w >= 0) && ((m_pv == 0) || consume || (w <= m_ps));
    wd_hit  = (WD != 0) && (m_wd == WD) && (m_cur_dir != 2) && (m_pv == 0);

    case (m_ph)
      M_START: begin
        m_off_dir = 2; m_off_spd = 0; m_off_src = N; m_ph = M_OFFER;
      end
      M_IDLE: begin
        if (m_pv != 0 && (m_pd != m_cur_dir || m_psp != m_cur_spd)) begin
          m_off_dir = m_pd; m_off_spd = m_psp; m_off_src = m_ps; m_ph = M_OFFER;
        end else if (m_ref == REF - 1) begin
          m_off_dir = m_cur_dir; m_off_spd = m_cur_spd; m_off_src = m_src; m_ph = M_OFFER;
        end
        m_ref++;
      end
      M_OFFER: begin
        if (rdy) begin
          m_cur_dir = m_off_dir; m_cur_spd = m_off_spd; m_src = m_off_src;
          m_ref = 0; m_ph = M_GAP;
        end
      end
      default: m_ph = M_IDLE;
    endcase

    if (consume) m_pv = 0;
    if (erise) begin
      m_pv = 1; m_pd = 2; m_psp = 0; m_ps = N;
    end else if (acc) begin
      m_pv = 1; m_pd = int'(rd[2*w +: 2]); m_psp = int'(rs[3*w +: 3]); m_ps = w;
      if (m_pd >= 2) begin m_pd = 2; m_psp = 0; end
    end else if (wd_hit) begin
      m_pv = 1; m_pd = 2; m_psp = 0; m_ps = N;
    end

    if (acc || wd_hit) m_wd = 0;
    else if (m_wd < WD) m_wd++;
    m_es = es ? 1 : 0;
  endtask

  // One clock: inputs already set by the caller; compare at the falling edge.
  task automatic tick();
    if (cv && rdy && !rst) dut_xfers++;
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("cmd_valid", cv, (m_ph == M_OFFER) ? 1 : 0);
    chk("cmd_dir", cd, (m_ph == M_OFFER) ? m_off_dir : m_cur_dir);
    chk("cmd_speed", cs, (m_ph == M_OFFER) ? m_off_spd : m_cur_spd);
    chk("active_src", asrc, m_src);
    chk("estop_active", ea, m_es);
  endtask

  task automatic strobe(input int i, input int d, input int s);
    rv = 3'(1 << i);
    rd[2*i +: 2] = 2'(d);
    rs[3*i +: 3] = 3'(s);
    tick();
    rv = '0;
  endtask

  initial begin
    // Reset and startup stop
    rst = 1'b1; rdy = 1'b1;
    repeat (3) tick();
    chk("rst_valid", cv, 0); chk("rst_dir", cd, 2); chk("rst_speed", cs, 0);
    chk("rst_src", asrc, 3); chk("rst_estop", ea, 0);
    rst = 1'b0; dut_xfers = 0;
    tick();
    chk("startup_valid", cv, 1); chk("startup_dir", cd, 2); chk("startup_speed", cs, 0);
    tick();
    chk("startup_xfer", dut_xfers, 1); chk("startup_src", asrc, 3); chk("gap_valid", cv, 0);
    repeat (101) tick();
    chk("pre_refresh_xfers", dut_xfers, 1); chk("refresh_offer", cv, 1);
    tick();
    chk("refresh_xfers", dut_xfers, 2);
    tick();

    // Simultaneous strobes from requesters 1 and 2
    x0 = dut_xfers;
    rv = 3'b110; rd = 6'b01_00_00; rs = {3'd7, 3'd5, 3'd0};
    tick(); rv = '0;
    chk("arb_latency_t1", cv, 0);
    tick();
    chk("arb_valid", cv, 1); chk("arb_dir", cd, 0); chk("arb_speed", cs, 5);
    repeat (4) tick();
    chk("arb_xfers", dut_xfers - x0, 1); chk("arb_src", asrc, 1);

    // Back-pressure while a lower-priority request queues up
    rdy = 1'b0; x0 = dut_xfers;
    strobe(0, 0, 3);
    tick();
    chk("hold_offer_valid", cv, 1);
    strobe(2, 1, 4);
    repeat (18) tick();
    chk("hold_valid", cv, 1); chk("hold_dir", cd, 0); chk("hold_speed", cs, 3);
    chk("hold_xfers", dut_xfers - x0, 0);
    rdy = 1'b1;
    tick();
    chk("hold_xfer_done", dut_xfers - x0, 1); chk("hold_gap_valid", cv, 0); chk("hold_src", asrc, 0);
    tick();
    chk("hold_idle_valid", cv, 0);
    tick();
    chk("queued_valid", cv, 1); chk("queued_dir", cd, 1); chk("queued_speed", cs, 4);
    tick();
    chk("queued_src", asrc, 2);

    // Emergency stop
    strobe(0, 0, 6);
    repeat (5) tick();
    chk("run_dir", cd, 0); chk("run_speed", cs, 6); chk("run_src", asrc, 0);
    es = 1'b1;
    tick();
    chk("estop_reg", ea, 1);
    repeat (6) tick();
    chk("estop_dir", cd, 2); chk("estop_speed", cs, 0); chk("estop_src", asrc, 3);
    repeat (250) begin
      rv = 3'($urandom_range(1, 7)); rd = 6'($urandom); rs = 9'($urandom);
      tick();
    end
    rv = '0;
    chk("estop_hold_dir", cd, 2); chk("estop_hold_src", asrc, 3);
    es = 1'b0;
    tick();

    // Watchdog: enabled instance forces stop, disabled instance keeps running
    strobe(1, 1, 2);
    repeat (5) tick();
    chk("wd_pre_dir", cd, 1); chk("wd_pre_speed", cs, 2); chk("wd_pre_src", asrc, 1);
    repeat (1020) tick();
    chk("wd_dir", cd, 2); chk("wd_speed", cs, 0); chk("wd_src", asrc, 3);
    chk("nowd_dir", cd2, 1); chk("nowd_speed", cs2, 2); chk("nowd_src", asrc2, 1);

    // Repeat of the current command leaves the refresh period alone
    strobe(0, 0, 5);
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (cv && cd == 2'd0 && cs == 3'd5) begin got = 1'b1; break; end
      tick();
    end
    chk("wait_offer_00_5", got, 1);
    tick();
    x0 = dut_xfers;
    repeat (30) tick();
    strobe(0, 0, 5);
    repeat (70) tick();
    chk("same_no_extra", dut_xfers - x0, 0); chk("same_refresh_offer", cv, 1);
    tick();
    chk("same_refresh_xfer", dut_xfers - x0, 1);

    // Reset while a command is being offered
    rdy = 1'b0;
    strobe(0, 1, 1);
    tick();
    chk("mid_valid", cv, 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", cv, 0); chk("mid_rst_dir", cd, 2); chk("mid_rst_src", asrc, 3);
    rst = 1'b0; rdy = 1'b1;
    tick();
    chk("restart_valid", cv, 1);

    // Random traffic against the model
    repeat (3000) begin
      rst = ($urandom_range(0, 799) == 0);
      if ($urandom_range(0, 149) == 0) es = ~es;
      rv  = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
      rd  = 6'($urandom);
      rs  = 9'($urandom);
      rdy = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
